// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32I opcode/funct7 constants and
// the funct3-to-operation mapping used by the issue stage decoder.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD                        = 4'd0,
    SUB                        = 4'd1,
    OR                         = 4'd2,
    XOR                        = 4'd3,
    AND                        = 4'd4,
    LesserThanUnsigned         = 4'd5,
    LesserThanSigned           = 4'd6,
    ShiftRightUnsigned         = 4'd7,
    ShiftRightSigned           = 4'd8,
    ShiftLeftUnsigned          = 4'd9,
    ShiftLeftSigned            = 4'd10,
    GreaterThanOrEqualUnsigned = 4'd11,
    GreaterThanOrEqualSigned   = 4'd12,
    Equal                      = 4'd13,
    NotEqual                   = 4'd14
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Base operation for a funct3 value; the funct7 alternates (SUB, SRA) are
  // applied by the decoder on top of this.
  function automatic alu_op_t base_op(input logic [2:0] funct3);
    alu_op_t op;
    case (funct3)
      3'b000:  op = ADD;
      3'b001:  op = ShiftLeftUnsigned;
      3'b010:  op = LesserThanSigned;
      3'b011:  op = LesserThanUnsigned;
      3'b100:  op = XOR;
      3'b101:  op = ShiftRightUnsigned;
      3'b110:  op = OR;
      default: op = AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake and writeback bundle for the ALU issue stage. The slave modport
// is the stage itself; the master modport is the surrounding pipeline.
interface alu_issue_stage_if
  import alu_pkg::*;
#(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            out_valid;
  logic            out_ready;
  alu_op_t         alu_op;
  logic [XLEN-1:0] alu_x;
  logic [XLEN-1:0] alu_y;
  logic [4:0]      rd;
  logic            illegal;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output in_valid, instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, alu_op, alu_x, alu_y, rd, illegal
  );

  modport slave (
    input  in_valid, instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, alu_op, alu_x, alu_y, rd, illegal
  );

endinterface

// File: rtl/alu_issue_stage_register_file.sv
// 32-entry integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero. Contents are not reset.
module register_file #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem [32];

  // Writes to x0 are dropped so the zero register never holds anything.
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : mem[raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-and-operand stage in front of the ALU. Decodes RV32I OP/OP-IMM,
// reads operands (with writeback bypass) and holds one registered request.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               reset,
  alu_issue_stage_if.slave  bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            accept;

  alu_op_t         dec_op;
  logic [XLEN-1:0] dec_x;
  logic [XLEN-1:0] dec_y;
  logic [4:0]      dec_rd;
  logic            dec_illegal;

  assign opcode   = bus.instr[6:0];
  assign funct3   = bus.instr[14:12];
  assign funct7   = bus.instr[31:25];
  assign rs1_addr = bus.instr[19:15];
  assign rs2_addr = bus.instr[24:20];

  register_file #(
    .XLEN (XLEN)
  ) u_register_file (
    .clk    (clk),
    .we     (bus.wb_en),
    .waddr  (bus.wb_rd),
    .wdata  (bus.wb_data),
    .raddr1 (rs1_addr),
    .rdata1 (rf_rdata1),
    .raddr2 (rs2_addr),
    .rdata2 (rf_rdata2)
  );

  // The stage can take a new instruction whenever the held slot is empty or
  // is being drained this cycle; out_valid is zero in reset so this is 1.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Same-cycle writeback bypass so a write on this edge is seen by the
  // instruction captured on the same edge.
  always_comb begin
    rs1_val = rf_rdata1;
    rs2_val = rf_rdata2;
    if (bus.wb_en && (bus.wb_rd == rs1_addr) && (rs1_addr != 5'd0)) begin
      rs1_val = bus.wb_data;
    end
    if (bus.wb_en && (bus.wb_rd == rs2_addr) && (rs2_addr != 5'd0)) begin
      rs2_val = bus.wb_data;
    end
  end

  // Decode OP/OP-IMM into operation and operands; anything else becomes an
  // illegal request with zeroed operands and an ADD operation.
  always_comb begin
    logic            legal;
    alu_op_t         op;
    logic [XLEN-1:0] y_val;
    logic            is_shift;

    legal    = 1'b0;
    op       = base_op(funct3);
    y_val    = rs2_val;
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    case (opcode)
      OPC_OP: begin
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            op = SUB;
          end else if (funct3 == 3'b101) begin
            op = ShiftRightSigned;
          end
        end
        y_val = rs2_val;
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          legal = (funct7 == F7_BASE) || ((funct7 == F7_ALT) && (funct3 == 3'b101));
          if ((funct7 == F7_ALT) && (funct3 == 3'b101)) begin
            op = ShiftRightSigned;
          end
          y_val = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
        end else begin
          legal = 1'b1;
          y_val = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
        end
      end
      default: begin
        legal = 1'b0;
      end
    endcase

    dec_op      = ADD;
    dec_x       = '0;
    dec_y       = '0;
    dec_rd      = '0;
    dec_illegal = 1'b1;
    if (legal) begin
      dec_op      = op;
      dec_x       = rs1_val;
      dec_y       = y_val;
      dec_rd      = bus.instr[11:7];
      dec_illegal = 1'b0;
    end
  end

  // One-entry output register: load on accept, drop on consume, otherwise
  // hold so the ALU sees stable inputs while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.alu_op    <= ADD;
      bus.alu_x     <= '0;
      bus.alu_y     <= '0;
      bus.rd        <= '0;
      bus.illegal   <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.alu_op    <= dec_op;
      bus.alu_x     <= dec_x;
      bus.alu_y     <= dec_y;
      bus.rd        <= dec_rd;
      bus.illegal   <= dec_illegal;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-operand stage feeding the CPU ALU. It accepts RV32I OP and OP-IMM instruction words over a valid/ready handshake, reads source registers from an internal 32×32 register file, and registers the ALU operation code, X/Y operands and destination register into a one-entry output stage. That output stage drives the ALU's `operation`, `X` and `Y` inputs directly. The same register file takes the writeback port from the stage after the ALU.

## Interface
- `XLEN`, 32: datapath width.
- `clk` input 1: clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `instr` is valid.
- `in_ready` output 1: stage accepts `instr` this cycle.
- `instr` input 32: RV32I instruction word.
- `out_valid` output 1: registered ALU request is valid.
- `out_ready` input 1: downstream consumes the request this cycle.
- `alu_op` output 4: ALU operation code.
- `alu_x` output XLEN: ALU X operand.
- `alu_y` output XLEN: ALU Y operand.
- `rd` output 5: destination register.
- `illegal` output 1: instruction was not a legal OP/OP-IMM.
- `wb_en` input 1: register-file write enable.
- `wb_rd` input 5: write address.
- `wb_data` input XLEN: write data.

## Operation
- Accept condition: `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, which gives one transfer per cycle at full throughput.
- Output hold: while `out_valid && !out_ready`, all outputs are held stable.
- Output release: `out_valid` clears on `out_ready` unless a new instruction is accepted in the same cycle.
- Operand read: rs1 is `instr[19:15]` and rs2 is `instr[24:20]`. Register x0 always reads 0.
- Writeback bypass: if `wb_en` is high and `wb_rd` equals rs (rs ≠ 0) in the accept cycle, the operand takes `wb_data`.
- Operand capture: operands are captured at accept. Later writes do not alter a held request.
- Writes: performed on every cycle with `wb_en` high, independent of the handshake. Writes to x0 are ignored.
- OP (opcode 0110011), selected by funct3:
  - 000: ADD, or SUB when funct7 = 0100000.
  - 001: ShiftLeftUnsigned.
  - 010: LesserThanSigned.
  - 011: LesserThanUnsigned.
  - 100: XOR.
  - 101: ShiftRightUnsigned, or ShiftRightSigned when funct7 = 0100000.
  - 110: OR.
  - 111: AND.
  - X = rs1 value, Y = rs2 value.
  - Legal funct7 values: 0000000 always; 0100000 only for funct3 000 and 101. Any other funct7 is illegal.
- OP-IMM (opcode 0010011): same mapping as OP with no SUB variant. X = rs1 value.
  - Non-shift: Y = sign-extended `instr[31:20]`.
  - Shifts: Y = {27'b0, `instr[24:20]`}. funct7 must be 0000000 (SLLI, SRLI) or 0100000 (SRAI), otherwise illegal.
- Illegal instructions (any other opcode or bad funct7) are still accepted as a transaction. Outputs: `illegal`=1, `alu_op`=ADD, `alu_x`=`alu_y`=0, `rd`=0.
- Reset:
  - `out_valid`=0, `alu_op`=0, `alu_x`=0, `alu_y`=0, `rd`=0, `illegal`=0.
  - `in_ready` is 1 as soon as reset is asserted.
  - Register file contents are not reset; bench code writes registers before reading them.
  - Reset asserted mid-stall drops the held request immediately.

## Timing
- Latency: an instruction accepted on edge N is presented with `out_valid`=1 after edge N. One cycle, no bubbles.
- Back-to-back: simultaneous consume and accept on the same edge replaces the held request with no gap.
- Write visibility: a write on edge N is visible to instructions accepted on edge N (through the bypass) and on every later edge.
- Register-file read is combinational; decode and bypass logic sit in front of the output register.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` with 4-bit codes: ADD=0, SUB=1, OR=2, XOR=3, AND=4, LesserThanUnsigned=5, LesserThanSigned=6, ShiftRightUnsigned=7, ShiftRightSigned=8, ShiftLeftUnsigned=9, ShiftLeftSigned=10, GreaterThanOrEqualUnsigned=11, GreaterThanOrEqualSigned=12, Equal=13, NotEqual=14.
  - Opcode constants `OPC_OP`, `OPC_OP_IMM`.
  - funct7 constants `F7_BASE`, `F7_ALT`.
- Sub-module `register_file`: 32×XLEN, two combinational read ports, one synchronous write port, x0 hardwired to 0.

## Test plan
- **Write, then ADD.** Write x1=5 and x2=7, then issue `add x3,x1,x2` (0x002081B3). Expect `alu_op`=ADD, X=5, Y=7, `rd`=3 one cycle after accept.
- **Immediate and shift decode.** Issue `addi x4,x0,-1` (0xFFF00213): expect X=0, Y=0xFFFFFFFF. Issue `srai x5,x1,3` (0x4030D293): expect ShiftRightSigned, Y=3.
- **Writeback bypass.** Write x6=0x1234 via `wb_en` in the same cycle that `sub x7,x6,x0` is accepted. Expect X=0x1234, `alu_op`=SUB.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles with `in_valid`=1. Expect `in_ready`=0, outputs stable, and an x6 write during the stall not reflected. Release `out_ready`: next instruction follows with no bubble.
- **Illegal.** Issue opcode 0x0000006F, or OP with funct7=0000001. Expect `illegal`=1, `rd`=0, X=Y=0, and the handshake completes.
- **Reset.** Drive `reset` low while `out_valid`=1. Expect `out_valid`=0 and all outputs 0 without waiting for a clock edge.
